// File: rtl/apdtimer_multi.sv
// apdtimer_multi: multi-channel APD timetagger front end with timestamped record FIFO
module apdtimer_multi #(
  parameter int N_STROBE = 4,
  parameter int N_DELTA = 4,
  parameter int TS_W = 36,
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_W = TS_W + N_STROBE + N_DELTA + 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          operate,
  input  logic                          reset_counter,
  input  logic [N_STROBE-1:0]           strobe_mask,
  input  logic [N_STROBE-1:0]           strobes,
  input  logic [N_DELTA-1:0]            delta_in,
  input  logic                          data_ack,
  output logic                          data_rdy,
  output logic [DATA_W-1:0]             data,
  output logic [15:0]                   lost_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [N_STROBE-1:0] st_s1, st_s2, st_s3, st_ev;
  logic [N_DELTA-1:0] dl_s1, dl_s2, dl_s3;
  logic [TS_W-1:0] cnt;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rp, wp;
  logic [AW:0] level;
  logic lost_pending, dl_ev, wrap_ev, push, pop, full, accept, drop;
  always_comb begin
    st_ev = st_s2 & ~st_s3 & strobe_mask & {N_STROBE{operate}};
    dl_ev = operate & (dl_s2 != dl_s3);
    wrap_ev = operate & ~reset_counter & (&cnt);
    push = (|st_ev) | dl_ev | wrap_ev;
    pop = data_rdy & data_ack;
    full = level == (AW+1)'(FIFO_DEPTH);
    accept = push & (~full | pop);
    drop = push & full & ~pop;
  end
  assign data_rdy = level != '0;
  assign data = data_rdy ? mem[rp] : '0;
  assign fifo_level = level;
  // history regs run even with operate low so enabling acquisition cannot fake an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      {st_s1, st_s2, st_s3} <= '0;
      {dl_s1, dl_s2, dl_s3} <= '0;
      cnt <= '0;
      rp <= '0;
      wp <= '0;
      level <= '0;
      lost_count <= '0;
      lost_pending <= 1'b0;
    end else begin
      st_s1 <= strobes;
      st_s2 <= st_s1;
      st_s3 <= st_s2;
      dl_s1 <= delta_in;
      dl_s2 <= dl_s1;
      dl_s3 <= dl_s2;
      cnt <= reset_counter ? '0 : cnt + TS_W'(operate);
      if (accept) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      level <= level + (AW+1)'(accept & ~pop) - (AW+1)'(pop & ~accept);
      if (drop && lost_count != 16'hFFFF) lost_count <= lost_count + 1'b1;
      lost_pending <= drop | (lost_pending & ~accept);
    end
  end
  // a full FIFO with a pop overwrites the slot being read this cycle, which is safe
  always_ff @(posedge clk) if (accept) mem[wp] <= {lost_pending, wrap_ev, dl_s2, st_ev, cnt};
endmodule

// File: doc/apdtimer_multi.md
Name: apdtimer_multi

Overview:
Parametrised successor to the 4-channel APD timetagger front end. Samples N_STROBE asynchronous detector inputs and N_DELTA pulse-sequencer levels, timestamps events against a free-running counter, and emits one record per event cycle. Records go through an internal FIFO with a valid/ack handshake toward the USB/readout side. Adds per-channel masking, counter-wrap records and dropped-record accounting.

Parameters:
N_STROBE, 4, detector (strobe) channel count, 1..16
N_DELTA, 4, pulse-sequencer (delta) channel count, 1..16
TS_W, 36, timestamp counter width, 8..48
FIFO_DEPTH, 16, record FIFO depth, power of 2, >=2
DATA_W, TS_W+N_STROBE+N_DELTA+2, record width (derived; do not override)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high block reset
operate  in  1  1 = acquire and count; 0 = hold counter, no new records
reset_counter  in  1  synchronous clear of the timestamp counter only
strobe_mask  in  N_STROBE  1 = channel enabled
strobes  in  N_STROBE  asynchronous detector pulses
delta_in  in  N_DELTA  asynchronous sequencer levels
data_ack  in  1  consumer accepts head record when data_rdy=1
data_rdy  out  1  FIFO non-empty (head record valid)
data  out  DATA_W  {lost, wrap, delta[N_DELTA-1:0], strobe[N_STROBE-1:0], ts[TS_W-1:0]}
lost_count  out  16  saturating count of dropped records
fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset (sync): counter=0, FIFO empty, data_rdy=0, data=0, lost_count=0, lost_pending=0, fifo_level=0, all synchroniser/previous-level regs=0.
- Input path: each strobes/delta_in bit passes 2-flop synchroniser (s1,s2) plus history reg s3.
- Strobe event on ch i: s2[i]&~s3[i]&strobe_mask[i]&operate. One event per rising edge, regardless of pulse width.
- Delta event: any bit with s2!=s3 while operate. Record delta field = current s2 levels (all bits, not only changed ones).
- History regs update every cycle regardless of operate; no spurious events when operate rises.
- Input high at reset release is a rising edge (history=0); one event on the 3rd edge after release.
- Counter: +1 per cycle while operate=1; holds when operate=0. reset_counter=1 -> 0 next edge; priority over increment. No wrap record on reset_counter.
- Wrap: counter==all-ones and operate=1 and reset_counter=0 -> wrap event.
- Record: at most one push per cycle. Push when any strobe, delta or wrap event. Strobe field = edge vector; wrap bit = wrap event; ts = counter value in the push cycle (pre-increment, pre-clear). Coincident strobe/delta/wrap events merge into one record.
- Latency: input sampled high by s1 at edge 0 -> pushed at edge 2 -> data_rdy=1 after edge 2 if FIFO was empty.
- FIFO: first-word-fall-through. data = head entry while data_rdy=1; data=0 when empty. Pop on data_rdy&data_ack; data_ack while empty is ignored.
- Full, push without pop: record dropped; lost_count+1 (saturates at 16'hFFFF); lost_pending=1.
- Full, push with pop in same cycle: push accepted, nothing dropped.
- lost bit = lost_pending at push time; lost_pending clears on next accepted push. A drop and an accept never occur in the same cycle.
- fifo_level: +1 on push-only, -1 on pop-only, unchanged on both or neither.
- operate=0: no pushes, counter frozen, FIFO keeps draining.
- reset mid-operation: FIFO contents discarded, lost_count cleared, same cycle.

Test Plan:
- Single event: N_STROBE=4, operate=1, counter cleared, 1-cycle pulse on strobes[0] -> one record; strobe=4'b0001, wrap=0, lost=0, ts = counter at push; data_rdy after 3rd edge.
- Merge/mask: strobe_mask=4'b1011, strobes 0,2,3 pulsed in the same cycle -> one record with strobe=4'b1001.
- Delta: delta_in 4'b0000 -> 4'b0100 -> one record with delta=4'b0100, strobe=0. delta_in constant -> no records.
- Wrap: TS_W=8, operate=1 from 0 -> wrap record ts=8'hFF, wrap=1, then counter=0. Strobe in wrap cycle -> merged into that record.
- Overflow: FIFO_DEPTH=4, data_ack=0, 6 separated strobes -> fifo_level=4, lost_count=2. Then data_ack=1 and one strobe -> 4 original records with lost=0, then new record with lost=1.
- Reset mid-run: FIFO holding 3 records, reset pulsed 1 cycle -> data_rdy=0, fifo_level=0, counter=0, lost_count=0 next cycle; reset_counter during event cycle -> record carries pre-clear ts.
